// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t         : receiver frame states
//   PAR_NONE/ODD/EVEN  : parity mode encodings used by the PARITY parameter
//   majority3()        : 2-of-3 vote used when UART_RX_MAJORITY_EN is defined
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Returns the value held by at least two of the three inputs.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchroniser for a single asynchronous bit. Every stage resets to
// 1 so an idle-high serial line does not look like a start bit out of reset.
// Ports:
//   i_clk    : destination clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : asynchronous input bit
//   o_sync   : synchronised output (STAGES cycles of delay)
// Parameters:
//   STAGES   : number of flops in the chain, >= 2
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver with input synchroniser, false-start rejection,
// framing/parity/overrun reporting and a valid/ready output handshake.
// Ports:
//   clk         : oversample clock, one tick per cycle
//   rst_n       : asynchronous active-low reset
//   din         : serial line, idle high, asynchronous to clk
//   data_ready  : consumer accepts the presented frame this cycle
//   data_valid  : data and flags valid, held until accepted
//   data        : received payload, LSB first on the wire
//   frame_err   : a stop bit was sampled low (qualified by data_valid)
//   parity_err  : parity mismatch (qualified by data_valid)
//   overrun     : sticky, a frame was dropped while output was still held
//   busy        : receiver is not idle
// Parameters:
//   OVERSAMPLE (even, >=8), DATA_BITS (5..9), PARITY (0 none, 1 odd, 2 even),
//   STOP_BITS (1 or 2), SYNC_STAGES (>=2)
// Build option:
//   UART_RX_MAJORITY_EN : each sample becomes a 2-of-3 vote over
//   centre-1/centre/centre+1 and every decision moves one cycle later.
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 data_ready,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);

`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_DELAY = 1;
`else
    localparam int SAMPLE_DELAY = 0;
`endif

    // The cycle that first sees rxd low counts as tick 0 of the start bit,
    // so START is entered with the counter already at 1.
    localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2 - 1 + SAMPLE_DELAY);
    localparam logic [TW-1:0] BIT_TICK   = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

    logic w_rxd;
    logic w_sample;
    logic w_parXor;
    logic w_parMismatch;
    logic w_ferrNext;

    uart_pkg::rx_state_t  r_state;
    logic [TW-1:0]        r_tick;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_pend;
    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_frameErr;
    logic                 r_parityErr;
    logic                 r_overrun;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (din),
        .o_sync  (w_rxd)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous rxd values; together with the current rxd they span
    // centre-1, centre and centre+1 when the decision is taken at centre+1.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rxd};
        end
    end

    assign w_sample = majority3(r_hist[1], r_hist[0], w_rxd);
`else
    assign w_sample = w_rxd;
`endif

    // Parity check covers the full payload plus the received parity bit.
    assign w_parXor      = ^{r_shreg, w_sample};
    assign w_parMismatch = (PARITY == PAR_ODD) ? ~w_parXor : w_parXor;
    assign w_ferrNext    = r_ferr | ~w_sample;

    // Frame FSM plus output register. A completed frame raises r_pend on the
    // final stop sample; the following edge either hands it to the consumer
    // or, if the previous frame is still being held, drops it and flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shreg     <= '0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;
            r_pend      <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_pend <= 1'b0;

            if (r_pend) begin
                if (!r_valid || data_ready) begin
                    r_valid     <= 1'b1;
                    r_data      <= r_shreg;
                    r_frameErr  <= r_ferr;
                    r_parityErr <= r_perr;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!w_rxd) begin
                        r_state <= START;
                        r_tick  <= TW'(1);
                    end
                end

                START: begin
                    if (r_tick == START_TICK) begin
                        r_tick <= '0;
                        if (w_sample) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                            r_bit   <= '0;
                            r_ferr  <= 1'b0;
                            r_perr  <= 1'b0;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                DATA: begin
                    if (r_tick == BIT_TICK) begin
                        r_tick  <= '0;
                        r_shreg <= {w_sample, r_shreg[DATA_BITS-1:1]};
                        if (r_bit == DATA_LAST) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                uart_pkg::PARITY: begin
                    if (r_tick == BIT_TICK) begin
                        r_tick  <= '0;
                        r_perr  <= w_parMismatch;
                        r_state <= STOP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                // Leaving at the centre of the last stop bit lets a start bit
                // that follows immediately be caught on time.
                STOP: begin
                    if (r_tick == BIT_TICK) begin
                        r_tick <= '0;
                        r_ferr <= w_ferrNext;
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            r_pend  <= 1'b1;
                            r_state <= w_ferrNext ? WAIT_HIGH : IDLE;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                // A held-low line (break) must return high before a new start.
                WAIT_HIGH: begin
                    if (w_rxd) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_valid = r_valid;
    assign data       = r_data;
    assign frame_err  = r_frameErr;
    assign parity_err = r_parityErr;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule
